// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Optional opcode legality check enabled by defining ALU_ARB_OPCHK_EN (adds the err output).
module alu_rr_arbiter #(
    parameter int ALU_LAT = 1,
    parameter int W       = 16
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [4:0]   req0_code,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [4:0]   req1_code,

    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_c,
    output logic         rsp0_vout,
    output logic         rsp0_cout,

    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_c,
    output logic         rsp1_vout,
    output logic         rsp1_cout,

    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [4:0]   alu_code,
    output logic         alu_coe,
    input  logic [W-1:0] alu_c,
    input  logic         alu_vout,
    input  logic         alu_cout,

    output logic         busy
`ifdef ALU_ARB_OPCHK_EN
    ,
    output logic         err
`endif
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, state_nxt;
    logic           last_grant;
    logic [CW-1:0]  cnt;

    logic           any_valid;
    logic           grant;
    logic           accept;
    logic           code_ok;
    logic           rsp_release;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [4:0]     sel_code;

    // Contention goes to whichever port was not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign any_valid   = req0_valid | req1_valid;
    assign accept      = (state == IDLE) && any_valid;
    assign req0_ready  = accept && !grant;
    assign req1_ready  = accept && grant;
    assign busy        = (state != IDLE);
    assign sel_a       = grant ? req1_a    : req0_a;
    assign sel_b       = grant ? req1_b    : req0_b;
    assign sel_code    = grant ? req1_code : req0_code;
    assign rsp_release = last_grant ? rsp1_ready : rsp0_ready;

`ifdef ALU_ARB_OPCHK_EN
    function automatic logic code_legal(input logic [4:0] code);
        case (code)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b01000, 5'b01001, 5'b01010, 5'b01100,
            5'b10000, 5'b10001, 5'b10010, 5'b10011,
            5'b11000, 5'b11001, 5'b11010, 5'b11011, 5'b11100, 5'b11101:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    assign code_ok = code_legal(sel_code);
`else
    assign code_ok = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = code_ok ? EXEC : RESP;
            EXEC:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_release) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant doubles as the owner of the in-flight operation until it is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_code   <= '0;
            alu_coe    <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp0_c     <= '0;
            rsp0_vout  <= 1'b0;
            rsp0_cout  <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_c     <= '0;
            rsp1_vout  <= 1'b0;
            rsp1_cout  <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            err        <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= grant;
                        if (code_ok) begin
                            alu_a    <= sel_a;
                            alu_b    <= sel_b;
                            alu_code <= sel_code;
                            alu_coe  <= 1'b0;
                            cnt      <= CW'(ALU_LAT - 1);
                        end else begin
                            if (grant) begin
                                rsp1_valid <= 1'b1;
                                rsp1_c     <= '0;
                                rsp1_vout  <= 1'b0;
                                rsp1_cout  <= 1'b0;
                            end else begin
                                rsp0_valid <= 1'b1;
                                rsp0_c     <= '0;
                                rsp0_vout  <= 1'b0;
                                rsp0_cout  <= 1'b0;
                            end
`ifdef ALU_ARB_OPCHK_EN
                            err <= 1'b1;
`endif
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        alu_coe <= 1'b1;
                        if (last_grant) begin
                            rsp1_valid <= 1'b1;
                            rsp1_c     <= alu_c;
                            rsp1_vout  <= alu_vout;
                            rsp1_cout  <= alu_cout;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_c     <= alu_c;
                            rsp0_vout  <= alu_vout;
                            rsp0_cout  <= alu_cout;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_release) begin
                        if (last_grant)
                            rsp1_valid <= 1'b0;
                        else
                            rsp0_valid <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
                        err <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of grants, latency and results.
module tb_alu_rr_arbiter;

    localparam int W       = 16;
    localparam int ALU_LAT = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]   req0_code, req1_code;
    logic         rsp0_valid, rsp0_ready, rsp0_vout, rsp0_cout;
    logic         rsp1_valid, rsp1_ready, rsp1_vout, rsp1_cout;
    logic [W-1:0] rsp0_c, rsp1_c;
    logic [W-1:0] alu_a, alu_b, alu_c;
    logic [4:0]   alu_code;
    logic         alu_coe, alu_vout, alu_cout, busy;
`ifdef ALU_ARB_OPCHK_EN
    logic         err;
`endif

    int tests = 0;
    int fails = 0;

    alu_rr_arbiter #(.ALU_LAT(ALU_LAT), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_code(req0_code),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_code(req1_code),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_vout(rsp0_vout), .rsp0_cout(rsp0_cout),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_vout(rsp1_vout), .rsp1_cout(rsp1_cout),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code), .alu_coe(alu_coe),
        .alu_c(alu_c), .alu_vout(alu_vout), .alu_cout(alu_cout),
        .busy(busy)
`ifdef ALU_ARB_OPCHK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in ALU: add, subtract (cout = borrow), anything else a code-dependent xor.
    function automatic logic [W+1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] code);
        logic [W:0] s;
        logic       v;
        case (code)
            5'd0: begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
                return {v, s[W], s[W-1:0]};
            end
            5'd1: begin
                s = {1'b0, a} - {1'b0, b};
                v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
                return {v, s[W], s[W-1:0]};
            end
            default: return {1'b0, code[0], a ^ b ^ {11'd0, code}};
        endcase
    endfunction

    assign {alu_vout, alu_cout, alu_c} = alu_f(alu_a, alu_b, alu_code);

`ifdef ALU_ARB_OPCHK_EN
    function automatic bit is_legal(input logic [4:0] code);
        logic [31:0] mask;
        mask = 32'h3F0F173F;
        return mask[code];
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_code = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_code = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({busy, rsp0_valid, rsp1_valid, alu_coe, req0_ready, req1_ready} !== 6'b000100) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000100", {busy, rsp0_valid, rsp1_valid, alu_coe, req0_ready, req1_ready});
        end
        tests++;
        if ({alu_a, alu_b, alu_code, rsp0_c, rsp1_c, rsp0_vout, rsp0_cout, rsp1_vout, rsp1_cout} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_data: alu_a=%h alu_b=%h code=%h rsp0_c=%h rsp1_c=%h expected all zero", alu_a, alu_b, alu_code, rsp0_c, rsp1_c);
        end
`ifdef ALU_ARB_OPCHK_EN
        tests++;
        if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
`endif
    endtask

    task automatic test_port0_add();
        req0_valid = 1'b1; req0_a = 16'hA00A; req0_b = 16'h1004; req0_code = 5'd0;
        #1;
        tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("[TB] FAIL p0_ready: got %b expected 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
        #1;
        tests++;
        if ({busy, alu_coe, rsp0_valid, alu_a, alu_b, alu_code} !== {3'b100, 16'hA00A, 16'h1004, 5'd0}) begin
            fails++;
            $display("[TB] FAIL p0_exec: busy/coe/rv=%b alu_a=%h alu_b=%h expected 100 A00A 1004", {busy, alu_coe, rsp0_valid}, alu_a, alu_b);
        end
        tick();
        tests++;
        if ({rsp0_valid, rsp1_valid, alu_coe, rsp0_vout, rsp0_cout, rsp0_c} !== {5'b10100, 16'hB00E}) begin
            fails++;
            $display("[TB] FAIL p0_rsp: got v=%b c=%h expected 10100 B00E", {rsp0_valid, rsp1_valid, alu_coe, rsp0_vout, rsp0_cout}, rsp0_c);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        tests++;
        if ({busy, rsp0_valid} !== 2'b00) begin fails++; $display("[TB] FAIL p0_release: got %b expected 00", {busy, rsp0_valid}); end
    endtask

    task automatic test_port1_add();
        req1_valid = 1'b1; req1_a = 16'h8012; req1_b = 16'h8002; req1_code = 5'd0;
        #1;
        tests++;
        if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("[TB] FAIL p1_ready: got %b expected 01", {req0_ready, req1_ready}); end
        tick();
        req1_valid = 1'b0;
        tick();
        tests++;
        if ({rsp1_valid, rsp0_valid, rsp1_vout, rsp1_cout, rsp1_c} !== {4'b1011, 16'h0014}) begin
            fails++;
            $display("[TB] FAIL p1_rsp: got flags=%b c=%h expected 1011 0014", {rsp1_valid, rsp0_valid, rsp1_vout, rsp1_cout}, rsp1_c);
        end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
    endtask

    task automatic test_fairness();
        int grants[$];
        do_reset();
        req0_valid = 1'b1; req0_a = 16'hF14A; req0_b = 16'hF002; req0_code = 5'd1;
        req1_valid = 1'b1; req1_a = 16'h8012; req1_b = 16'h8002; req1_code = 5'd0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && grants.size() < 4; cyc++) begin
            #1;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp0_valid) begin
                tests++;
                if ({rsp1_valid, rsp0_vout, rsp0_cout, rsp0_c} !== {3'b000, 16'h0148}) begin
                    fails++;
                    $display("[TB] FAIL fair_rsp0: got flags=%b c=%h expected 000 0148", {rsp1_valid, rsp0_vout, rsp0_cout}, rsp0_c);
                end
            end
            if (rsp1_valid) begin
                tests++;
                if ({rsp0_valid, rsp1_vout, rsp1_cout, rsp1_c} !== {3'b011, 16'h0014}) begin
                    fails++;
                    $display("[TB] FAIL fair_rsp1: got flags=%b c=%h expected 011 0014", {rsp0_valid, rsp1_vout, rsp1_cout}, rsp1_c);
                end
            end
            tick();
        end
        tests++;
        if (grants.size() < 4) begin
            fails++;
            $display("[TB] FAIL fair_timeout: got %0d grants expected 4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (grants[i] != (i % 2)) begin
                    fails++;
                    $display("[TB] FAIL fair_order[%0d]: got port %0d expected %0d", i, grants[i], i % 2);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_backpressure();
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0001; req0_code = 5'd0;
        req1_valid = 1'b1; req1_a = 16'h2222; req1_b = 16'h0003; req1_code = 5'd0;
        tick();
        req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({rsp0_valid, busy, req1_ready, rsp1_valid, rsp0_c} !== {4'b1100, 16'h1235}) begin
                fails++;
                $display("[TB] FAIL hold[%0d]: got flags=%b c=%h expected 1100 1235", i, {rsp0_valid, busy, req1_ready, rsp1_valid}, rsp0_c);
            end
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        tests++;
        if ({busy, rsp0_valid, req1_ready} !== 3'b001) begin
            fails++;
            $display("[TB] FAIL hold_release: got %b expected 001", {busy, rsp0_valid, req1_ready});
        end
        tick();
        req1_valid = 1'b0;
        tests++;
        if ({busy, alu_a} !== {1'b1, 16'h2222}) begin
            fails++;
            $display("[TB] FAIL hold_next_grant: busy=%b alu_a=%h expected 1 2222", busy, alu_a);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_a = 16'h0F0F; req0_b = 16'h0101; req0_code = 5'd0;
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({busy, rsp0_valid, rsp1_valid, alu_coe, alu_a, alu_code} !== {4'b0001, 16'h0000, 5'd0}) begin
            fails++;
            $display("[TB] FAIL midrst_state: got flags=%b alu_a=%h code=%h expected 0001 0000 00", {busy, rsp0_valid, rsp1_valid, alu_coe}, alu_a, alu_code);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL midrst_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        do_reset();
    endtask

    task automatic test_opcode();
        req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0004; req0_code = 5'd3;
        rsp0_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h5555; req0_b = 16'hAAAA; req0_code = 5'b00110;
        tick();
        req0_valid = 1'b0;
`ifdef ALU_ARB_OPCHK_EN
        tests++;
        if ({rsp0_valid, err, busy, alu_coe, rsp0_vout, rsp0_cout, rsp0_c, alu_code, alu_a} !== {6'b111100, 16'h0000, 5'd3, 16'h0003}) begin
            fails++;
            $display("[TB] FAIL opchk_illegal: flags=%b c=%h code=%h alu_a=%h expected 111100 0000 03 0003",
                     {rsp0_valid, err, busy, alu_coe, rsp0_vout, rsp0_cout}, rsp0_c, alu_code, alu_a);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        tests++;
        if ({err, rsp0_valid, busy} !== 3'b000) begin fails++; $display("[TB] FAIL opchk_clear: got %b expected 000", {err, rsp0_valid, busy}); end
`else
        tests++;
        if ({rsp0_valid, alu_code, alu_a} !== {1'b0, 5'b00110, 16'h5555}) begin
            fails++;
            $display("[TB] FAIL opcode_pass: rv=%b code=%h alu_a=%h expected 0 06 5555", rsp0_valid, alu_code, alu_a);
        end
        tick();
        tests++;
        if ({rsp0_valid, rsp0_vout, rsp0_cout, rsp0_c} !== {1'b1, alu_f(16'h5555, 16'hAAAA, 5'b00110)}) begin
            fails++;
            $display("[TB] FAIL opcode_rsp: flags=%b c=%h expected 100 FFF9", {rsp0_valid, rsp0_vout, rsp0_cout}, rsp0_c);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
`endif
        do_reset();
    endtask

    // Model tracks only: who is owed a result, how many edges remain, and who was served last.
    task automatic test_random();
        bit            m_busy, m_resp, m_last, m_port, m_err;
        int            m_cnt;
        logic [W+1:0]  m_exp;
        bit            e0, e1, rel, g;
        logic [W-1:0]  ga, gb;
        logic [4:0]    gc;
        do_reset();
        m_busy = 0; m_resp = 0; m_last = 1; m_port = 0; m_err = 0; m_cnt = 0; m_exp = '0;
        for (int it = 0; it < 600; it++) begin
            req0_valid = ($urandom % 2) == 1;
            req1_valid = ($urandom % 2) == 1;
            req0_a = 16'($urandom); req0_b = 16'($urandom);
            req1_a = 16'($urandom); req1_b = 16'($urandom);
            req0_code = (($urandom % 4) == 0) ? 5'($urandom) : 5'($urandom % 2);
            req1_code = (($urandom % 4) == 0) ? 5'($urandom) : 5'($urandom % 2);
            rsp0_ready = ($urandom % 4) != 0;
            rsp1_ready = ($urandom % 4) != 0;
            #1;
            e0 = !m_busy && req0_valid && (!req1_valid || m_last);
            e1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            tests++;
            if ({req0_ready, req1_ready} !== {e0, e1}) begin
                fails++;
                $display("[TB] FAIL rnd_ready[%0d]: got %b expected %b", it, {req0_ready, req1_ready}, {e0, e1});
            end
            rel = m_resp && (m_port ? rsp1_ready : rsp0_ready);
            g  = e1;
            ga = g ? req1_a : req0_a;
            gb = g ? req1_b : req0_b;
            gc = g ? req1_code : req0_code;
            tick();
            if (rel) begin
                m_busy = 0; m_resp = 0; m_err = 0;
            end else if (m_busy && !m_resp) begin
                m_cnt--;
                if (m_cnt == 0) m_resp = 1;
            end
            if (e0 || e1) begin
                m_busy = 1; m_resp = 0; m_last = g; m_port = g; m_cnt = ALU_LAT; m_err = 0;
                m_exp  = alu_f(ga, gb, gc);
`ifdef ALU_ARB_OPCHK_EN
                if (!is_legal(gc)) begin m_resp = 1; m_exp = '0; m_err = 1; end
`endif
            end
            tests++;
            if ({busy, rsp0_valid, rsp1_valid} !== {m_busy, m_resp && !m_port, m_resp && m_port}) begin
                fails++;
                $display("[TB] FAIL rnd_state[%0d]: got %b expected %b", it, {busy, rsp0_valid, rsp1_valid}, {m_busy, m_resp && !m_port, m_resp && m_port});
            end
            if (m_resp) begin
                tests++;
                if ((m_port ? {rsp1_vout, rsp1_cout, rsp1_c} : {rsp0_vout, rsp0_cout, rsp0_c}) !== m_exp) begin
                    fails++;
                    $display("[TB] FAIL rnd_data[%0d]: port %0d got %h expected %h", it, m_port,
                             m_port ? {rsp1_vout, rsp1_cout, rsp1_c} : {rsp0_vout, rsp0_cout, rsp0_c}, m_exp);
                end
            end
`ifdef ALU_ARB_OPCHK_EN
            tests++;
            if (err !== m_err) begin fails++; $display("[TB] FAIL rnd_err[%0d]: got %b expected %b", it, err, m_err); end
`endif
        end
        do_reset();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_port0_add();
        test_port1_add();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_opcode();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one combinational 16-bit ALU between two requesters (port 0, port 1) using round-robin arbitration and valid/ready handshakes.
- Registers the granted operands and alu_code onto the ALU inputs.
- Waits a configurable settle time, then captures C/vout/cout.
- Returns the result on the granted requester's response channel.
- One operation is in flight at a time. Sits between ALU clients (sequencer, test engine) and the ALU instance.

Parameters:
ALU_LAT, 1, cycles the ALU inputs are held before capture (>=1)
W, 16, operand/result width (must match the ALU)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_a  in  W  port 0 operand A
req0_b  in  W  port 0 operand B
req0_code  in  5  port 0 alu_code
req1_valid/req1_ready/req1_a/req1_b/req1_code  same as port 0, for port 1
rsp0_valid  out  1  port 0 result valid
rsp0_ready  in  1  port 0 result consumed
rsp0_c  out  W  result C
rsp0_vout  out  1  overflow flag
rsp0_cout  out  1  carry flag
rsp1_valid/rsp1_ready/rsp1_c/rsp1_vout/rsp1_cout  same as port 0, for port 1
alu_a  out  W  ALU operand A (registered)
alu_b  out  W  ALU operand B (registered)
alu_code  out  5  ALU opcode (registered)
alu_coe  out  1  ALU carry-out enable, active low
alu_c  in  W  ALU result
alu_vout  in  1  ALU overflow
alu_cout  in  1  ALU carry
busy  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values (on rst at posedge, any state): state=IDLE, last_grant=1 (port 0 wins first), all rsp*_valid=0, rsp*_c=0, rsp flags=0, alu_a=alu_b=0, alu_code=0, alu_coe=1, busy=0, settle counter=0.
- Reset mid-operation: the in-flight operation is dropped with no response.
- IDLE arbitration (combinational):
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the port != last_grant.
  - reqN_ready=1 only for the granted port, only in IDLE. Both readys are 0 in EXEC/RESP.
- Acceptance edge (valid&ready):
  - Load alu_a/alu_b/alu_code from the granted port.
  - alu_coe<=0; last_grant<=granted port; counter<=ALU_LAT-1; go to EXEC.
  - Request fields are sampled only at this edge; later changes are ignored.
- EXEC:
  - ALU inputs held stable.
  - Counter decrements each cycle.
  - Edge where counter==0: capture alu_c/vout/cout into the granted port's rsp registers, set that rspN_valid=1, alu_coe<=1, go to RESP.
  - Latency: rspN_valid rises ALU_LAT+1 edges after the acceptance edge counts from acceptance (ALU_LAT=1: 2 edges).
- RESP:
  - rspN_valid and its data are held until rspN_ready=1 at an edge.
  - That edge clears rspN_valid and returns to IDLE.
  - The next grant occurs no earlier than the following cycle.
  - The other port's rsp_valid stays 0 throughout.
- Fairness: under continuous requests from both ports, grants alternate 0,1,0,1...
- A port that deasserts valid before being granted loses nothing; no state is kept.
- alu_code is passed through unmodified (except under the optional feature). Arithmetic is entirely in the ALU; the arbiter adds no width change.

Optional Feature:
- Macro: ALU_ARB_OPCHK_EN.
- Enabled:
  - At acceptance, alu_code is checked against the 20 legal codes: 00000-00101, 01000, 01001, 01010, 01100, 10000-10011, 11000-11101.
  - An illegal code skips EXEC: the FSM goes IDLE->RESP directly with rsp c=0, vout=0, cout=0.
  - An extra output err (1 bit, reset 0) is 1 while that response is valid.
  - alu_* outputs are not updated for an illegal code.
- Disabled: no check, no err port; every code executes.

Test Plan:
1. req0 add (00000), A=A00A, B=1004, ALU_LAT=1 -> rsp0_valid 2 cycles after accept, C=B00E, vout=0, cout=0.
2. req1 add, A=8012, B=8002 -> C=0014, vout=1, cout=1; rsp1 only, rsp0_valid stays 0.
3. Both valid every cycle from reset, rsp_ready tied 1 -> grant order 0,1,0,1; each op returns the correct requester's result, e.g. port0 sub F14A-F002 -> C=0148.
4. rsp0_ready held 0 for 5 cycles -> rsp0 data stable, busy=1, req1_ready=0 throughout; released -> IDLE, then req1 granted next cycle.
5. rst asserted during EXEC -> next cycle all outputs at reset values; next both-valid grant goes to port 0.
6. With ALU_ARB_OPCHK_EN, code 00110 -> RESP one edge after accept, C=0000, err=1, alu_code unchanged; without the macro, 00110 reaches alu_code.
